mont_exp_param: RTL

//  Parametrised Montgomery modular exponentiation: result = message^d mod m for any operand WIDTH.

---
 rtl/mont_exp_param_pkg.sv | 23 ++
 rtl/mont_exp_param_if.sv | 29 ++
 rtl/mont_exp_param_mont_mul.sv | 82 ++++++++
 rtl/mont_exp_param.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mont_exp_param_pkg.sv
// Shared types and defaults for the Montgomery exponentiation slice.
package mont_exp_param_pkg;

  localparam int DEFAULT_WIDTH     = 1024;
  localparam int DEFAULT_EXP_WIDTH = 1024;
  localparam int DEFAULT_LEN_W     = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TOMONT,
    ST_SQUARE,
    ST_MULT,
    ST_FROMMONT,
    ST_DONE
  } exp_state_t;

  // mont_mul handshake: start is a one-cycle pulse while idle; done is a one-cycle pulse with result valid
  typedef enum logic {
    MM_IDLE,
    MM_RUN
  } mm_state_t;

endpackage

// File: rtl/mont_exp_param_if.sv
// Host-side request/response bundle for mont_exp_param.
interface mont_exp_param_if #(
  parameter int WIDTH     = mont_exp_param_pkg::DEFAULT_WIDTH,
  parameter int EXP_WIDTH = mont_exp_param_pkg::DEFAULT_EXP_WIDTH,
  parameter int LEN_W     = mont_exp_param_pkg::DEFAULT_LEN_W
) ();
  logic                 start;
  logic                 ct_mode;
  logic [WIDTH-1:0]     in_m;
  logic [WIDTH-1:0]     r_modm;
  logic [WIDTH-1:0]     r2_modm;
  logic [WIDTH-1:0]     message;
  logic [EXP_WIDTH-1:0] d;
  logic [LEN_W-1:0]     e_len;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     result;
  logic [LEN_W+1:0]     mm_count;

  modport master (
    output start, ct_mode, in_m, r_modm, r2_modm, message, d, e_len,
    input  busy, done, result, mm_count
  );

  modport slave (
    input  start, ct_mode, in_m, r_modm, r2_modm, message, d, e_len,
    output busy, done, result, mm_count
  );
endinterface

// File: rtl/mont_exp_param_mont_mul.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod m, one a-bit per cycle.
module mont_mul
  import mont_exp_param_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  mm_state_t        state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, m_q;
  logic [WIDTH+1:0] s_q, s_add, s_odd, s_step, m_ext;
  logic [WIDTH-1:0] s_fin;
  logic [CW-1:0]    cnt_q;
  logic             last;

  // Partial sum stays below 2m, so two guard bits cover s + b + m.
  always_comb begin
    m_ext  = {2'b00, m_q};
    s_add  = s_q + (a_q[0] ? {2'b00, b_q} : '0);
    s_odd  = s_add[0] ? (s_add + m_ext) : s_add;
    s_step = s_odd >> 1;
    s_fin  = WIDTH'((s_step >= m_ext) ? (s_step - m_ext) : s_step);
    last   = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_nx = state;
    case (state)
      MM_IDLE: if (start) state_nx = MM_RUN;
      MM_RUN:  if (last)  state_nx = MM_IDLE;
      default: state_nx = MM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= MM_IDLE;
      done   <= 1'b0;
      result <= '0;
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      s_q    <= '0;
      cnt_q  <= '0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      case (state)
        MM_IDLE: begin
          if (start) begin
            a_q   <= in_a;
            b_q   <= in_b;
            m_q   <= in_m;
            s_q   <= '0;
            cnt_q <= '0;
          end
        end
        MM_RUN: begin
          s_q   <= s_step;
          a_q   <= a_q >> 1;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            result <= s_fin;
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mont_exp_param.sv
// MSB-first square-and-multiply modular exponentiation over one shared mont_mul.
module mont_exp_param
  import mont_exp_param_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int EXP_WIDTH = DEFAULT_EXP_WIDTH,
  parameter int LEN_W     = DEFAULT_LEN_W
) (
  input logic              clk,
  input logic              resetn,
  mont_exp_param_if.slave  bus
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(EXP_WIDTH);

  exp_state_t           state, state_nx;
  logic [WIDTH-1:0]     m_q, r2_q, msg_q, xt_q, acc_q, result_q;
  logic [EXP_WIDTH-1:0] d_q;
  logic [LEN_W-1:0]     len_q, i_q, len_in;
  logic                 ct_q, done_q, issued_q;
  logic [LEN_W+1:0]     mm_count_q;

  logic                 mm_start, mm_done, d_bit, last_bit;
  logic [WIDTH-1:0]     op_a, op_b, mm_res;

  mont_mul #(.WIDTH(WIDTH)) u_mont_mul (
    .clk    (clk),
    .resetn (resetn),
    .start  (mm_start),
    .in_a   (op_a),
    .in_b   (op_b),
    .in_m   (m_q),
    .result (mm_res),
    .done   (mm_done)
  );

  always_comb begin
    len_in   = (bus.e_len > LEN_MAX) ? LEN_MAX : bus.e_len;
    d_bit    = |(d_q & (EXP_WIDTH'(1) << i_q));
    last_bit = (i_q == '0);
  end

  // Next state, operand mux and start pulse; start fires once on the first cycle of each multiply state.
  always_comb begin
    state_nx = state;
    mm_start = 1'b0;
    op_a     = '0;
    op_b     = '0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) state_nx = ST_TOMONT;
      end
      ST_TOMONT: begin
        op_a     = msg_q;
        op_b     = r2_q;
        mm_start = !issued_q;
        if (mm_done) state_nx = (len_q != '0) ? ST_SQUARE : ST_FROMMONT;
      end
      ST_SQUARE: begin
        op_a     = acc_q;
        op_b     = acc_q;
        mm_start = !issued_q;
        if (mm_done) begin
          if (ct_q || d_bit) state_nx = ST_MULT;
          else               state_nx = last_bit ? ST_FROMMONT : ST_SQUARE;
        end
      end
      ST_MULT: begin
        op_a     = acc_q;
        op_b     = xt_q;
        mm_start = !issued_q;
        if (mm_done) state_nx = last_bit ? ST_FROMMONT : ST_SQUARE;
      end
      ST_FROMMONT: begin
        op_a     = acc_q;
        op_b     = WIDTH'(1);
        mm_start = !issued_q;
        if (mm_done) state_nx = ST_DONE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      m_q        <= '0;
      r2_q       <= '0;
      msg_q      <= '0;
      xt_q       <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      d_q        <= '0;
      len_q      <= '0;
      i_q        <= '0;
      ct_q       <= 1'b0;
      done_q     <= 1'b0;
      issued_q   <= 1'b0;
      mm_count_q <= '0;
    end else begin
      state  <= state_nx;
      done_q <= 1'b0;
      if (mm_start) begin
        issued_q   <= 1'b1;
        mm_count_q <= mm_count_q + (LEN_W+2)'(1);
      end
      if (mm_done) issued_q <= 1'b0;

      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            m_q        <= bus.in_m;
            r2_q       <= bus.r2_modm;
            msg_q      <= bus.message;
            d_q        <= bus.d;
            ct_q       <= bus.ct_mode;
            len_q      <= len_in;
            i_q        <= len_in - LEN_W'(1);
            acc_q      <= bus.r_modm;
            mm_count_q <= '0;
          end
        end
        ST_TOMONT: if (mm_done) xt_q <= mm_res;
        ST_SQUARE: begin
          if (mm_done) begin
            acc_q <= mm_res;
            if (!(ct_q || d_bit) && !last_bit) i_q <= i_q - LEN_W'(1);
          end
        end
        ST_MULT: begin
          if (mm_done) begin
            if (d_bit)     acc_q <= mm_res;
            if (!last_bit) i_q   <= i_q - LEN_W'(1);
          end
        end
        ST_FROMMONT: begin
          if (mm_done) begin
            result_q <= mm_res;
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state == ST_TOMONT) || (state == ST_SQUARE) ||
                        (state == ST_MULT)   || (state == ST_FROMMONT);
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.mm_count = mm_count_q;

endmodule
